// File: rtl/traj_pkg.sv
// Shared types, fixed-point widths and Q-format helpers for the trajectory step engine.
package traj_pkg;

   localparam int unsigned POS_W = 16;
   localparam int unsigned VEL_W = 16;
   localparam int unsigned FRAC  = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StEmit = 2'd1,
      StCalc = 2'd2
   } state_e;

   // 256.0 in Q12.4: first x position whose integer part no longer fits the 8-bit output
   localparam logic signed [POS_W-1:0] X_LIMIT = 16'sh1000;
   localparam logic signed [POS_W-1:0] X_CLAMP = 16'sh0FF0;

   function automatic logic signed [VEL_W-1:0] vel_from_u44(input logic [7:0] v);
      return {8'h00, v};
   endfunction

   function automatic logic signed [VEL_W-1:0] vel_from_s44(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

   function automatic logic signed [VEL_W-1:0] grav_from_q04(input logic [3:0] g);
      return {12'h000, g};
   endfunction

   // Integer part of a Q12.4 position, floored at 0 and saturated at 255
   function automatic logic [7:0] pos_int_sat(input logic signed [POS_W-1:0] p);
      if (p[POS_W-1]) begin
         return 8'h00;
      end
      if (p[POS_W-2:FRAC+8] != '0) begin
         return 8'hFF;
      end
      return p[FRAC+7:FRAC];
   endfunction

endpackage

// File: rtl/traj_step_engine_if.sv
// Launch request and sample stream port of the trajectory step engine.
interface traj_step_engine_if;

   logic       start;
   logic [7:0] vx0;
   logic [7:0] vy0;
   logic [3:0] grav;
   logic       busy;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_x;
   logic [7:0] out_y;
   logic [7:0] out_step;
   logic       out_last;

   modport master (
      input  start, vx0, vy0, grav, out_ready,
      output busy, out_valid, out_x, out_y, out_step, out_last
   );

   modport slave (
      output start, vx0, vy0, grav, out_ready,
      input  busy, out_valid, out_x, out_y, out_step, out_last
   );

endinterface

// File: rtl/traj_euler_step.sv
// Combinational explicit-Euler update with x-overflow clamp and landing detection.
// Linear drag on vx is included when TRAJ_DRAG_EN is defined.
module traj_euler_step
   import traj_pkg::*;
`ifdef TRAJ_DRAG_EN
#(
   parameter int unsigned DRAG_SHIFT = 3
)
`endif
(
   input  logic signed [POS_W-1:0] i_x,
   input  logic signed [POS_W-1:0] i_y,
   input  logic signed [VEL_W-1:0] i_vx,
   input  logic signed [VEL_W-1:0] i_vy,
   input  logic signed [VEL_W-1:0] i_g,
   output logic signed [POS_W-1:0] o_x,
   output logic signed [POS_W-1:0] o_y,
   output logic signed [VEL_W-1:0] o_vx,
   output logic signed [VEL_W-1:0] o_vy,
   output logic                    o_x_ovf,
   output logic                    o_landed
);

   logic signed [POS_W-1:0] w_x_sum;
   logic signed [POS_W-1:0] w_y_sum;

   assign w_x_sum  = i_x + i_vx;
   assign w_y_sum  = i_y + i_vy;
   assign o_x_ovf  = (w_x_sum >= X_LIMIT);
   // Exactly zero height is still airborne; only a negative height counts as landing
   assign o_landed = w_y_sum[POS_W-1];
   assign o_x      = o_x_ovf ? X_CLAMP : w_x_sum;
   assign o_y      = o_landed ? '0 : w_y_sum;
   assign o_vy     = i_vy - i_g;

`ifdef TRAJ_DRAG_EN
   assign o_vx = i_vx - (i_vx >>> DRAG_SHIFT);
`else
   assign o_vx = i_vx;
`endif

endmodule

// File: rtl/traj_step_engine.sv
// Projectile integrator: latches launch state, steps Euler and streams (x,y) samples.
// Optional linear drag on vx via the TRAJ_DRAG_EN macro.
module traj_step_engine
   import traj_pkg::*;
#(
   parameter int unsigned MAX_STEPS  = 255,
   parameter int unsigned DRAG_SHIFT = 3
) (
   input logic                clk,
   input logic                rst,
   traj_step_engine_if.master io_traj
);

   state_e                  r_state;
   state_e                  w_state_d;
   logic signed [POS_W-1:0] r_x, r_y, w_x_n, w_y_n;
   logic signed [VEL_W-1:0] r_vx, r_vy, r_g, w_vx_n, w_vy_n;
   logic [7:0]              r_step, w_step_n;
   logic                    r_last, w_last_n;
   logic                    w_x_ovf, w_landed, w_load, w_calc;

   if (MAX_STEPS < 1 || MAX_STEPS > 255) begin : g_bad_max_steps
      $error("MAX_STEPS must be in 1..255");
   end
   if (DRAG_SHIFT >= VEL_W) begin : g_bad_drag_shift
      $error("DRAG_SHIFT must be below the velocity width");
   end

   traj_euler_step
`ifdef TRAJ_DRAG_EN
   #(
      .DRAG_SHIFT(DRAG_SHIFT)
   )
`endif
   u_euler_step (
      .i_x      (r_x),
      .i_y      (r_y),
      .i_vx     (r_vx),
      .i_vy     (r_vy),
      .i_g      (r_g),
      .o_x      (w_x_n),
      .o_y      (w_y_n),
      .o_vx     (w_vx_n),
      .o_vy     (w_vy_n),
      .o_x_ovf  (w_x_ovf),
      .o_landed (w_landed)
   );

   assign w_step_n = r_step + 8'd1;
   assign w_last_n = w_x_ovf | w_landed | (w_step_n == 8'(MAX_STEPS));

   always_comb begin
      w_state_d = r_state;
      w_load    = 1'b0;
      w_calc    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (io_traj.start) begin
               w_load    = 1'b1;
               w_state_d = StEmit;
            end
         end
         StEmit: begin
            if (io_traj.out_ready) begin
               w_state_d = r_last ? StIdle : StCalc;
            end
         end
         StCalc: begin
            w_calc    = 1'b1;
            w_state_d = StEmit;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_x     <= '0;
         r_y     <= '0;
         r_vx    <= '0;
         r_vy    <= '0;
         r_g     <= '0;
         r_step  <= '0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         if (w_load) begin
            r_x    <= '0;
            r_y    <= '0;
            r_vx   <= vel_from_u44(io_traj.vx0);
            r_vy   <= vel_from_s44(io_traj.vy0);
            r_g    <= grav_from_q04(io_traj.grav);
            r_step <= '0;
            r_last <= 1'b0;
         end else if (w_calc) begin
            r_x    <= w_x_n;
            r_y    <= w_y_n;
            r_vx   <= w_vx_n;
            r_vy   <= w_vy_n;
            r_step <= w_step_n;
            r_last <= w_last_n;
         end
      end
   end

   assign io_traj.busy      = (r_state != StIdle);
   assign io_traj.out_valid = (r_state == StEmit);
   assign io_traj.out_last  = r_last & (r_state == StEmit);
   assign io_traj.out_x     = pos_int_sat(r_x);
   assign io_traj.out_y     = pos_int_sat(r_y);
   assign io_traj.out_step  = r_step;

endmodule

// File: tb/tb_traj_step_engine.sv
// Scoreboard bench: directed launches push expected samples, monitors pop and compare.
module tb_traj_step_engine;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] step;
      logic       last;
   } smp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   traj_step_engine_if tif ();
   traj_step_engine_if tif8 ();

   traj_step_engine #(
      .MAX_STEPS  (255),
      .DRAG_SHIFT (3)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .io_traj (tif)
   );

   traj_step_engine #(
      .MAX_STEPS  (8),
      .DRAG_SHIFT (3)
   ) u_dut8 (
      .clk     (clk),
      .rst     (rst),
      .io_traj (tif8)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   smp_t q0[$];
   smp_t q8[$];

   logic [7:0] t1_y [11] = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd4, 8'd3, 8'd2, 8'd0, 8'd0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cmp_sample(input string tag, input smp_t got, input smp_t e);
      n_checks++;
      if (got !== e) begin
         n_errors++;
         $display("FAIL %s sample: got x=%0d y=%0d step=%0d last=%0d expected x=%0d y=%0d step=%0d last=%0d",
                  tag, got.x, got.y, got.step, got.last, e.x, e.y, e.step, e.last);
      end
   endtask

   always @(negedge clk) begin
      smp_t got;
      if (!rst && tif.out_valid && tif.out_ready) begin
         got = '{tif.out_x, tif.out_y, tif.out_step, tif.out_last};
         if (q0.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut unexpected sample: got step=%0d expected none", tif.out_step);
         end else begin
            cmp_sample("dut", got, q0.pop_front());
            check("dut busy with valid", 32'(tif.busy), 32'd1);
         end
      end
   end

   always @(negedge clk) begin
      smp_t got;
      if (!rst && tif8.out_valid && tif8.out_ready) begin
         got = '{tif8.out_x, tif8.out_y, tif8.out_step, tif8.out_last};
         if (q8.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut8 unexpected sample: got step=%0d expected none", tif8.out_step);
         end else begin
            cmp_sample("dut8", got, q8.pop_front());
         end
      end
   end

   task automatic launch(input bit sel8, input logic [7:0] vx, input logic [7:0] vy,
                         input logic [3:0] g);
      @(posedge clk);
      #1;
      if (sel8) begin
         tif8.vx0 = vx; tif8.vy0 = vy; tif8.grav = g; tif8.start = 1'b1;
      end else begin
         tif.vx0 = vx; tif.vy0 = vy; tif.grav = g; tif.start = 1'b1;
      end
      @(posedge clk);
      #1;
      tif.start  = 1'b0;
      tif8.start = 1'b0;
   endtask

   task automatic wait_idle(input bit sel8, input string name);
      int cyc = 0;
      while (((sel8 ? q8.size() : q0.size()) != 0 || (sel8 ? tif8.busy : tif.busy)) &&
             cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (cyc >= 3000) begin
         n_errors++;
         $display("FAIL %s timeout: got %0d samples pending expected 0", name,
                  sel8 ? q8.size() : q0.size());
         q0.delete();
         q8.delete();
      end
   endtask

   task automatic wait_step(input logic [7:0] s, input string name);
      int cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(tif.out_valid && tif.out_step == s) && cyc < 1000);
      if (cyc >= 1000) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s wait for step: got none expected step %0d", name, s);
      end
   endtask

   task automatic push_test1();
      for (int n = 0; n < 11; n++) begin
         q0.push_back('{8'(n), t1_y[n], 8'(n), (n == 10)});
      end
   endtask

   initial begin
      int xv;
      int yv;
      tif.start = 1'b0; tif.vx0 = '0; tif.vy0 = '0; tif.grav = '0; tif.out_ready = 1'b1;
      tif8.start = 1'b0; tif8.vx0 = '0; tif8.vy0 = '0; tif8.grav = '0; tif8.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 32'(tif.busy), 32'd0);
      check("reset out_valid", 32'(tif.out_valid), 32'd0);
      check("reset out_last", 32'(tif.out_last), 32'd0);
      check("reset out_x", 32'(tif.out_x), 32'd0);
      check("reset out_y", 32'(tif.out_y), 32'd0);
      check("reset out_step", 32'(tif.out_step), 32'd0);
      rst = 1'b0;

      // Basic arc, lands at step 10
      push_test1();
      launch(1'b0, 8'h10, 8'h20, 4'd8);
      wait_idle(1'b0, "arc");

      // Back-pressure at step 3
      push_test1();
      launch(1'b0, 8'h10, 8'h20, 4'd8);
      wait_step(8'd2, "stall");
      @(posedge clk);
      #1;
      tif.out_ready = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall out_valid", 32'(tif.out_valid), 32'd1);
         check("stall out_x", 32'(tif.out_x), 32'd3);
         check("stall out_y", 32'(tif.out_y), 32'd4);
         check("stall out_step", 32'(tif.out_step), 32'd3);
      end
      @(posedge clk);
      #1;
      tif.out_ready = 1'b1;
      wait_idle(1'b0, "stall");

      // x overflow: 255 at step 16 not last, clamp and last at 17
      for (int n = 0; n <= 17; n++) begin
         xv = (255 * n) / 16;
         if (xv > 255) xv = 255;
         q0.push_back('{8'(xv), 8'(n), 8'(n), (n == 17)});
      end
      launch(1'b0, 8'hFF, 8'h10, 4'd0);
      wait_idle(1'b0, "xovf");

      // Step limit on the MAX_STEPS=8 instance
      for (int n = 0; n <= 8; n++) begin
         q8.push_back('{8'd0, 8'(n), 8'(n), (n == 8)});
      end
      launch(1'b1, 8'h01, 8'h10, 4'd0);
      wait_idle(1'b1, "maxsteps");

      // Start while busy is ignored
      push_test1();
      launch(1'b0, 8'h10, 8'h20, 4'd8);
      wait_step(8'd2, "ignore start");
      @(posedge clk);
      #1;
      tif.vx0 = 8'h40; tif.vy0 = 8'h70; tif.grav = 4'd1; tif.start = 1'b1;
      @(posedge clk);
      #1;
      tif.start = 1'b0;
      wait_idle(1'b0, "ignore start");
      repeat (3) @(negedge clk);
      check("ignore start idle after", 32'(tif.busy), 32'd0);

      // Immediate landing on step 1 with downward launch
      q0.push_back('{8'd0, 8'd0, 8'd0, 1'b0});
      q0.push_back('{8'd1, 8'd0, 8'd1, 1'b1});
      launch(1'b0, 8'h10, 8'hF0, 4'd0);
      wait_idle(1'b0, "land1");

      // out_y saturation, runs to the full step limit
      for (int n = 0; n <= 255; n++) begin
         yv = (127 * n) / 16;
         if (yv > 255) yv = 255;
         q0.push_back('{8'(n / 16), 8'(yv), 8'(n), (n == 255)});
      end
      launch(1'b0, 8'h01, 8'h7F, 4'd0);
      wait_idle(1'b0, "ysat");

      // Reset drops a pending sample, then relaunch from step 0
      tif.out_ready = 1'b0;
      launch(1'b0, 8'h10, 8'h20, 4'd8);
      wait_step(8'd0, "reset drop");
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst out_valid", 32'(tif.out_valid), 32'd0);
      check("rst busy", 32'(tif.busy), 32'd0);
      check("rst out_step", 32'(tif.out_step), 32'd0);
      tif.out_ready = 1'b1;
      push_test1();
      launch(1'b0, 8'h10, 8'h20, 4'd8);
      wait_idle(1'b0, "relaunch");

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
